cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_lru.sv | 51 +++++
 rtl/ram.sv | 49 ++++
 rtl/cache.sv | 244 ++++++++++++++++++++++++
 tb/tb_cache.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry defaults, FSM encoding and LRU reset helper for the cache
package cache_pkg;

   localparam int DEF_WIDTH        = 32;
   localparam int DEF_MWIDTH       = 32;
   localparam int DEF_NSETS        = 64;
   localparam int DEF_NWAYS        = 4;
   localparam int DEF_BLOCK_SIZE   = 32;
   localparam int DEF_INDEX_WIDTH  = 6;
   localparam int DEF_TAG_WIDTH    = 8;
   localparam int DEF_OFFSET_WIDTH = 3;
   localparam int DEF_ADDR_WIDTH   = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WRITE_BACK,
      S_FETCH,
      S_WAIT,
      S_FILL
   } state_t;

   // Way w starts with age w, so way 0 is the first replacement candidate.
   function automatic logic [2*DEF_NWAYS-1:0] init_ages();
      logic [2*DEF_NWAYS-1:0] r;
      r = '0;
      for (int w = 0; w < DEF_NWAYS; w++) begin
         r[2*w +: 2] = 2'(w);
      end
      return r;
   endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - age-based LRU update and victim choice for one 4-way set
module cache_lru
   import cache_pkg::*;
#(
   parameter int NWAYS = DEF_NWAYS
) (
   input  logic [2*NWAYS-1:0] ages_i,
   input  logic [NWAYS-1:0]   valid_i,
   input  logic [1:0]         access_way_i,
   output logic [2*NWAYS-1:0] ages_o,
   output logic [1:0]         victim_o
);

   logic [1:0] old_age;
   logic [1:0] cur_age;
   logic       found;

   // Ages stay a permutation of 0..3: only ways younger-ranked than the accessed one shift down.
   always_comb begin
      old_age = ages_i[2*access_way_i +: 2];
      cur_age = '0;
      ages_o  = ages_i;
      for (int w = 0; w < NWAYS; w++) begin
         cur_age = ages_i[2*w +: 2];
         if (w == int'(access_way_i)) begin
            ages_o[2*w +: 2] = 2'd3;
         end else if (cur_age > old_age) begin
            ages_o[2*w +: 2] = cur_age - 2'd1;
         end
      end
   end

   always_comb begin
      victim_o = '0;
      found    = 1'b0;
      for (int w = NWAYS-1; w >= 0; w--) begin
         if (!valid_i[w]) begin
            victim_o = 2'(w);
            found    = 1'b1;
         end
      end
      if (!found) begin
         for (int w = NWAYS-1; w >= 0; w--) begin
            if (ages_i[2*w +: 2] == 2'd0) begin
               victim_o = 2'(w);
            end
         end
      end
   end

endmodule

// File: rtl/ram.sv
// rtl/ram.sv - single-port write-first memory model with registered read data and valid pulse
module ram
   import cache_pkg::*;
#(
   parameter int WIDTH      = DEF_MWIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [WIDTH-1:0]      data_out,
   output logic                  valid_out
);

   logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;

   always_comb begin
      data_out_d  = data_out_q;
      valid_out_d = read_enable;
      if (read_enable) begin
         data_out_d = write_enable ? data_in : mem_q[address];
      end
   end

   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem_q[address] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q  <= '0;
         valid_out_q <= 1'b0;
      end else begin
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

endmodule

// File: rtl/cache.sv
// rtl/cache.sv - 4-way set-associative write-back, write-allocate cache with one-word lines
module cache
   import cache_pkg::*;
#(
   parameter int WIDTH        = DEF_WIDTH,
   parameter int MWIDTH       = DEF_MWIDTH,
   parameter int NSETS        = DEF_NSETS,
   parameter int NWAYS        = DEF_NWAYS,
   parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
   parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
   parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
   parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [WIDTH-1:0]      din,
   input  logic                  rden,
   input  logic                  wren,
   output logic [WIDTH-1:0]      q,
   output logic                  hit_miss,
   output logic [MWIDTH-1:0]     mdout,
   output logic [ADDR_WIDTH-1:0] mwraddress,
   output logic                  mwren,
   output logic [ADDR_WIDTH-1:0] mrdaddress,
   output logic                  mrden,
   input  logic [MWIDTH-1:0]     mq
);

   localparam int TI_WIDTH = INDEX_WIDTH + TAG_WIDTH;

   if (WIDTH != MWIDTH || BLOCK_SIZE != MWIDTH || NWAYS != 4 || NSETS != 2**INDEX_WIDTH ||
       (2**OFFSET_WIDTH) * WIDTH < BLOCK_SIZE) begin : g_bad_cfg
      $error("cache: unsupported geometry");
   end

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      din_q, din_d;
   logic                  wr_q, wr_d;
   logic [1:0]            victim_q, victim_d;
   logic [WIDTH-1:0]      q_q, q_d;
   logic                  hit_miss_q, hit_miss_d;
   logic                  mrden_q, mrden_d;
   logic                  mwren_q, mwren_d;
   logic [MWIDTH-1:0]     mdout_q, mdout_d;
   logic [ADDR_WIDTH-1:0] mwraddress_q, mwraddress_d;
   logic [ADDR_WIDTH-1:0] mrdaddress_q, mrdaddress_d;

   logic [NWAYS-1:0]   valid_q [NSETS];
   logic [NWAYS-1:0]   dirty_q [NSETS];
   logic [2*NWAYS-1:0] age_q   [NSETS];
   logic [TAG_WIDTH-1:0] tag_q  [NSETS][NWAYS];
   logic [MWIDTH-1:0]    data_q [NSETS][NWAYS];

   logic [INDEX_WIDTH-1:0] idx;
   logic [TAG_WIDTH-1:0]   tag;
   logic                   hit;
   logic [1:0]             hit_way;
   logic [1:0]             access_way;
   logic [2*NWAYS-1:0]     lru_ages;
   logic [1:0]             lru_victim;

   logic                   line_we;
   logic [1:0]             line_way;
   logic [MWIDTH-1:0]      line_data;
   logic                   line_dirty;
   logic                   age_we;

   assign idx = addr_q[INDEX_WIDTH-1:0];
   assign tag = addr_q[TI_WIDTH-1:INDEX_WIDTH];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NWAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = 2'(w);
         end
      end
   end

   assign access_way = (state_q == S_FILL) ? victim_q : hit_way;

   cache_lru #(
      .NWAYS(NWAYS)
   ) u_lru (
      .ages_i      (age_q[idx]),
      .valid_i     (valid_q[idx]),
      .access_way_i(access_way),
      .ages_o      (lru_ages),
      .victim_o    (lru_victim)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      din_d        = din_q;
      wr_d         = wr_q;
      victim_d     = victim_q;
      q_d          = q_q;
      hit_miss_d   = hit_miss_q;
      mrden_d      = 1'b0;
      mwren_d      = 1'b0;
      mdout_d      = mdout_q;
      mwraddress_d = mwraddress_q;
      mrdaddress_d = mrdaddress_q;
      line_we      = 1'b0;
      line_way     = hit_way;
      line_data    = din_q;
      line_dirty   = 1'b1;
      age_we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wren || rden) begin
               addr_d  = address;
               din_d   = din;
               wr_d    = wren;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               hit_miss_d = 1'b1;
               age_we     = 1'b1;
               if (wr_q) begin
                  line_we = 1'b1;
               end else begin
                  q_d = data_q[idx][hit_way];
               end
               state_d = S_IDLE;
            end else begin
               hit_miss_d = 1'b0;
               victim_d   = lru_victim;
               if (valid_q[idx][lru_victim] && dirty_q[idx][lru_victim]) begin
                  mwren_d                     = 1'b1;
                  mwraddress_d                = '0;
                  mwraddress_d[TI_WIDTH-1:0]  = {tag_q[idx][lru_victim], idx};
                  mdout_d                     = data_q[idx][lru_victim];
                  state_d                     = S_WRITE_BACK;
               end else begin
                  mrden_d      = 1'b1;
                  mrdaddress_d = addr_q;
                  state_d      = S_FETCH;
               end
            end
         end
         S_WRITE_BACK: begin
            mrden_d      = 1'b1;
            mrdaddress_d = addr_q;
            state_d      = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_FILL;
         end
         S_FILL: begin
            // A write-allocate fill discards the fetched word and keeps q as it was.
            line_we    = 1'b1;
            line_way   = victim_q;
            line_data  = wr_q ? din_q : mq;
            line_dirty = wr_q;
            age_we     = 1'b1;
            if (!wr_q) begin
               q_d = mq;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         din_q        <= '0;
         wr_q         <= 1'b0;
         victim_q     <= '0;
         q_q          <= '0;
         hit_miss_q   <= 1'b0;
         mrden_q      <= 1'b0;
         mwren_q      <= 1'b0;
         mdout_q      <= '0;
         mwraddress_q <= '0;
         mrdaddress_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         wr_q         <= wr_d;
         victim_q     <= victim_d;
         q_q          <= q_d;
         hit_miss_q   <= hit_miss_d;
         mrden_q      <= mrden_d;
         mwren_q      <= mwren_d;
         mdout_q      <= mdout_d;
         mwraddress_q <= mwraddress_d;
         mrdaddress_q <= mrdaddress_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < NSETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            age_q[s]   <= init_ages();
         end
      end else begin
         if (line_we) begin
            valid_q[idx][line_way] <= 1'b1;
            dirty_q[idx][line_way] <= line_dirty;
         end
         if (age_we) begin
            age_q[idx] <= lru_ages;
         end
      end
   end

   // Payload needs no reset: valid bits gate every use of it.
   always_ff @(posedge clk) begin
      if (line_we) begin
         data_q[idx][line_way] <= line_data;
         tag_q[idx][line_way]  <= tag;
      end
   end

   assign q          = q_q;
   assign hit_miss   = hit_miss_q;
   assign mrden      = mrden_q;
   assign mwren      = mwren_q;
   assign mdout      = mdout_q;
   assign mwraddress = mwraddress_q;
   assign mrdaddress = mrdaddress_q;

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - scoreboard bench for cache with a ram backing store
module tb_cache;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] address;
   logic [31:0] din;
   logic        rden, wren;
   logic [31:0] q;
   logic        hit_miss;
   logic [31:0] mdout;
   logic [15:0] mwraddress, mrdaddress;
   logic        mwren, mrden;
   logic [31:0] mq;
   logic        ram_valid;

   logic        pre_en;
   logic [15:0] pre_addr;
   logic [31:0] pre_data;

   always #5 clk = ~clk;

   cache dut (
      .clk(clk), .reset_n(reset_n), .address(address), .din(din),
      .rden(rden), .wren(wren), .q(q), .hit_miss(hit_miss),
      .mdout(mdout), .mwraddress(mwraddress), .mwren(mwren),
      .mrdaddress(mrdaddress), .mrden(mrden), .mq(mq)
   );

   ram u_ram (
      .clk(clk), .reset_n(reset_n),
      .address(pre_en ? pre_addr : (mwren ? mwraddress : mrdaddress)),
      .data_in(pre_en ? pre_data : mdout),
      .write_enable(pre_en | mwren),
      .read_enable(pre_en ? 1'b0 : mrden),
      .data_out(mq), .valid_out(ram_valid)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        hit;
      logic [31:0] q;
      int          nrd;
      int          nwr;
      logic [15:0] rda;
      logic [15:0] wba;
      logic [31:0] wbd;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_en = 1'b1;

   bit          prev_busy = 1'b0;
   bit          both_seen = 1'b0;
   int          nrd_seen = 0;
   int          nwr_seen = 0;
   logic [15:0] rda_seen = '0;
   logic [15:0] wba_seen = '0;
   logic [31:0] wbd_seen = '0;

   always @(negedge clk) begin
      if (!reset_n || !mon_en) begin
         prev_busy = 1'b0;
         both_seen = 1'b0;
         nrd_seen  = 0;
         nwr_seen  = 0;
      end else begin
         if (mrden && mwren) both_seen = 1'b1;
         if (mwren) begin
            nwr_seen++;
            wba_seen = mwraddress;
            wbd_seen = mdout;
         end
         if (mrden) begin
            nrd_seen++;
            rda_seen = mrdaddress;
         end
         if (prev_busy && dut.state_q == S_IDLE) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("hit_miss", {31'd0, hit_miss}, {31'd0, e.hit});
               chk("q", q, e.q);
               chk("mrden_pulses", nrd_seen, e.nrd);
               chk("mwren_pulses", nwr_seen, e.nwr);
               chk("mem_exclusive", {31'd0, both_seen}, 32'd0);
               if (e.nrd > 0) chk("mrdaddress", {16'd0, rda_seen}, {16'd0, e.rda});
               if (e.nwr > 0) begin
                  chk("mwraddress", {16'd0, wba_seen}, {16'd0, e.wba});
                  chk("mdout", wbd_seen, e.wbd);
               end
            end
            both_seen = 1'b0;
            nrd_seen  = 0;
            nwr_seen  = 0;
         end
         prev_busy = (dut.state_q != S_IDLE);
      end
   end

   task automatic do_op(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic ehit, input logic [31:0] eq, input int enrd, input int enwr,
                        input logic [15:0] erda, input logic [15:0] ewba, input logic [31:0] ewbd);
      exp_t e;
      int   n;
      e.hit = ehit; e.q = eq; e.nrd = enrd; e.nwr = enwr;
      e.rda = erda; e.wba = ewba; e.wbd = ewbd;
      @(negedge clk);
      exp_q.push_back(e);
      address = a; din = d; rden = rd; wren = wr;
      @(posedge clk);
      #1 rden = 1'b0; wren = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dut.state_q != S_IDLE && n < 50);
      chk("op_timeout", {31'd0, n < 50}, 32'd1);
      @(negedge clk);
   endtask

   task automatic rd_op(input logic [15:0] a, input logic ehit, input logic [31:0] eq,
                        input int enrd, input int enwr, input logic [15:0] ewba,
                        input logic [31:0] ewbd);
      do_op(1'b1, 1'b0, a, 32'd0, ehit, eq, enrd, enwr, a, ewba, ewbd);
   endtask

   logic [15:0] pre_list [11] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600,
                                  16'h0700, 16'h0a00, 16'h0c00, 16'h0041, 16'h3fff};

   initial begin
      int n;
      reset_n = 1'b0; rden = 1'b0; wren = 1'b0; address = '0; din = '0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         pre_en   = 1'b1;
         pre_addr = pre_list[i];
         pre_data = 32'ha5a50000 | {16'd0, pre_list[i]};
      end
      @(negedge clk);
      pre_en = 1'b0;
      chk("rst_q", q, 32'd0);
      chk("rst_hit_miss", {31'd0, hit_miss}, 32'd0);
      chk("rst_mem_strobes", {30'd0, mrden, mwren}, 32'd0);
      chk("rst_mdout", mdout, 32'd0);
      chk("rst_addrs", {mwraddress, mrdaddress}, 32'd0);
      chk("rst_ages_set0", {24'd0, dut.age_q[0]}, 32'h000000e4);
      reset_n = 1'b1;
      @(negedge clk);

      rd_op(16'h0100, 1'b0, 32'ha5a50100, 1, 0, 16'h0, 32'h0);
      rd_op(16'h0200, 1'b0, 32'ha5a50200, 1, 0, 16'h0, 32'h0);
      rd_op(16'h0300, 1'b0, 32'ha5a50300, 1, 0, 16'h0, 32'h0);
      rd_op(16'h0400, 1'b0, 32'ha5a50400, 1, 0, 16'h0, 32'h0);
      chk("set0_valid_full", {28'd0, dut.valid_q[0]}, 32'hf);
      chk("ages_after_cold", {24'd0, dut.age_q[0]}, 32'he4);

      rd_op(16'h0500, 1'b0, 32'ha5a50500, 1, 0, 16'h0, 32'h0);
      chk("ages_after_evict", {24'd0, dut.age_q[0]}, 32'h93);

      rd_op(16'h0200, 1'b1, 32'ha5a50200, 0, 0, 16'h0, 32'h0);
      rd_op(16'h0300, 1'b1, 32'ha5a50300, 0, 0, 16'h0, 32'h0);
      rd_op(16'h0400, 1'b1, 32'ha5a50400, 0, 0, 16'h0, 32'h0);
      chk("ages_after_hits", {24'd0, dut.age_q[0]}, 32'he4);

      do_op(1'b0, 1'b1, 16'h0a00, 32'h0dda4444, 1'b0, 32'ha5a50400, 1, 0, 16'h0a00, 16'h0, 32'h0);
      chk("dirty_after_wr_alloc", {28'd0, dut.dirty_q[0]}, 32'h1);
      rd_op(16'h0a00, 1'b1, 32'h0dda4444, 0, 0, 16'h0, 32'h0);

      do_op(1'b1, 1'b1, 16'h0200, 32'h12345678, 1'b1, 32'h0dda4444, 0, 0, 16'h0, 16'h0, 32'h0);
      rd_op(16'h0200, 1'b1, 32'h12345678, 0, 0, 16'h0, 32'h0);
      rd_op(16'h0300, 1'b1, 32'ha5a50300, 0, 0, 16'h0, 32'h0);
      rd_op(16'h0400, 1'b1, 32'ha5a50400, 0, 0, 16'h0, 32'h0);

      rd_op(16'h0600, 1'b0, 32'ha5a50600, 1, 1, 16'h0a00, 32'h0dda4444);
      rd_op(16'h0a00, 1'b0, 32'h0dda4444, 1, 1, 16'h0200, 32'h12345678);

      rd_op(16'h0041, 1'b0, 32'ha5a50041, 1, 0, 16'h0, 32'h0);
      rd_op(16'h3fff, 1'b0, 32'ha5a53fff, 1, 0, 16'h0, 32'h0);
      rd_op(16'hc041, 1'b1, 32'ha5a50041, 0, 0, 16'h0, 32'h0);

      mon_en = 1'b0;
      @(negedge clk);
      address = 16'h0700; rden = 1'b1;
      @(posedge clk);
      #1 rden = 1'b0;
      n = 0;
      while (dut.state_q != S_WAIT && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wait", {31'd0, dut.state_q == S_WAIT}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_state_idle", {31'd0, dut.state_q == S_IDLE}, 32'd1);
      chk("arst_q", q, 32'd0);
      chk("arst_hit_miss", {31'd0, hit_miss}, 32'd0);
      chk("arst_mem_strobes", {30'd0, mrden, mwren}, 32'd0);
      chk("arst_mdout", mdout, 32'd0);
      chk("arst_addrs", {mwraddress, mrdaddress}, 32'd0);
      chk("arst_valid_set0", {28'd0, dut.valid_q[0]}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      rd_op(16'h0c00, 1'b0, 32'ha5a50c00, 1, 0, 16'h0, 32'h0);
      chk("valid_after_cold", {28'd0, dut.valid_q[0]}, 32'h1);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
